// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : alu_op_sequencer_if
// Brief  : Command, response and ALU-pin bundle for alu_op_sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 3,
   parameter int CNT_W  = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [OP_W-1:0]   cmd_opcode;
   logic [DATA_W-1:0] cmd_a;
   logic [DATA_W-1:0] cmd_b;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic [OP_W-1:0]   rsp_opcode;

   logic              alu_en;
   logic [OP_W-1:0]   alu_opcode;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;

   logic              busy;
   logic [CNT_W-1:0]  op_count;

   // master: command source, response sink and the ALU itself
   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready, alu_result,
      input  cmd_ready, rsp_valid, rsp_result, rsp_opcode,
             alu_en, alu_opcode, alu_a, alu_b, busy, op_count
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready, alu_result,
      output cmd_ready, rsp_valid, rsp_result, rsp_opcode,
             alu_en, alu_opcode, alu_a, alu_b, busy, op_count
   );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_op_sequencer
// Brief  : Queues ALU commands and issues them one at a time, returning results.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
   parameter int DATA_W  = 32,
   parameter int OP_W    = 3,
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_op_sequencer_if.slave bus
);

   localparam int c_AW    = $clog2(DEPTH);
   localparam int c_ENT_W = OP_W + 2 * DATA_W;
   localparam int c_CW    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(ALU_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [c_ENT_W-1:0]  r_mem [DEPTH];
   logic [c_AW:0]       r_wptr;
   logic [c_AW:0]       r_rptr;
   logic [c_ENT_W-1:0]  w_head;
   logic                w_empty;
   logic                w_full;
   logic                w_push;
   logic                w_pop;
   logic                w_capture;
   logic                w_done;

   logic [c_CW-1:0]     r_cnt;
   logic                r_alu_en;
   logic [OP_W-1:0]     r_alu_opcode;
   logic [DATA_W-1:0]   r_alu_a;
   logic [DATA_W-1:0]   r_alu_b;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_result;
   logic [OP_W-1:0]     r_rsp_opcode;
   logic [CNT_W-1:0]    r_op_count;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                    (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
   assign w_push  = bus.cmd_valid && !w_full;
   assign w_head  = r_mem[r_rptr[c_AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[c_AW-1:0]] <= {bus.cmd_opcode, bus.cmd_a, bus.cmd_b};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (r_rsp_valid && bus.rsp_ready) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_cnt        <= '0;
         r_alu_en     <= 1'b0;
         r_alu_opcode <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_opcode <= '0;
         r_op_count   <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + (c_AW+1)'(1);
         end
         // ALU operands stay on the pins after the op until the next pop.
         if (w_pop) begin
            r_rptr       <= r_rptr + (c_AW+1)'(1);
            r_alu_opcode <= w_head[c_ENT_W-1 -: OP_W];
            r_alu_a      <= w_head[2*DATA_W-1 -: DATA_W];
            r_alu_b      <= w_head[DATA_W-1:0];
            r_alu_en     <= 1'b1;
            r_cnt        <= c_CNT_LOAD;
         end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CW'(1);
         end
         if (w_capture) begin
            r_rsp_result <= bus.alu_result;
            r_rsp_opcode <= r_alu_opcode;
            r_alu_en     <= 1'b0;
            r_rsp_valid  <= 1'b1;
         end
         if (w_done) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + CNT_W'(1);
         end
      end
   end

   assign bus.cmd_ready  = !w_full;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_result = r_rsp_result;
   assign bus.rsp_opcode = r_rsp_opcode;
   assign bus.alu_en     = r_alu_en;
   assign bus.alu_opcode = r_alu_opcode;
   assign bus.alu_a      = r_alu_a;
   assign bus.alu_b      = r_alu_b;
   assign bus.busy       = (r_state != S_IDLE) || !w_empty;
   assign bus.op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_op_sequencer
// Brief  : Self-checking bench: DUT A (ALU_LAT=1), DUT B (ALU_LAT=3, CNT_W=3).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } cmd_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel   = 1'b0;
   int unsigned tick  = 0;
   int          checks   = 0;
   int          failures = 0;
   int          cnt_model [2];

   logic        d_cmd_valid = 1'b0;
   logic        d_rsp_ready = 1'b0;
   logic [2:0]  d_op = '0;
   logic [31:0] d_a  = '0;
   logic [31:0] d_b  = '0;

   logic        m_cmd_ready, m_rsp_valid, m_alu_en, m_busy;
   logic [31:0] m_rsp_result, m_alu_a, m_alu_b;
   logic [2:0]  m_rsp_opcode, m_alu_opcode;
   logic [15:0] m_op_count;

   cmd_t        pend [$];
   logic [34:0] iss  [$];
   vec_t        vecs [8];

   alu_op_sequencer_if #(.DATA_W(32), .OP_W(3), .CNT_W(16)) ifa ();
   alu_op_sequencer_if #(.DATA_W(32), .OP_W(3), .CNT_W(3))  ifb ();

   alu_op_sequencer #(.DATA_W(32), .OP_W(3), .DEPTH(4), .ALU_LAT(1), .CNT_W(16)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   alu_op_sequencer #(.DATA_W(32), .OP_W(3), .DEPTH(4), .ALU_LAT(3), .CNT_W(3)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) tick <= tick + 1;

   function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << b[4:0];
         3'd6:    return a >> b[4:0];
         default: return {31'b0, ($signed(a) < $signed(b))};
      endcase
   endfunction

   // DUT A's ALU is combinational; DUT B's result also drifts every cycle.
   assign ifa.alu_result = alu_fn(ifa.alu_opcode, ifa.alu_a, ifa.alu_b);
   assign ifb.alu_result = alu_fn(ifb.alu_opcode, ifb.alu_a, ifb.alu_b) + tick;

   assign ifa.cmd_valid  = d_cmd_valid && !sel;
   assign ifb.cmd_valid  = d_cmd_valid && sel;
   assign ifa.rsp_ready  = d_rsp_ready && !sel;
   assign ifb.rsp_ready  = d_rsp_ready && sel;
   assign ifa.cmd_opcode = d_op;
   assign ifb.cmd_opcode = d_op;
   assign ifa.cmd_a      = d_a;
   assign ifb.cmd_a      = d_a;
   assign ifa.cmd_b      = d_b;
   assign ifb.cmd_b      = d_b;

   assign m_cmd_ready  = sel ? ifb.cmd_ready  : ifa.cmd_ready;
   assign m_rsp_valid  = sel ? ifb.rsp_valid  : ifa.rsp_valid;
   assign m_rsp_result = sel ? ifb.rsp_result : ifa.rsp_result;
   assign m_rsp_opcode = sel ? ifb.rsp_opcode : ifa.rsp_opcode;
   assign m_alu_en     = sel ? ifb.alu_en     : ifa.alu_en;
   assign m_alu_opcode = sel ? ifb.alu_opcode : ifa.alu_opcode;
   assign m_alu_a      = sel ? ifb.alu_a      : ifa.alu_a;
   assign m_alu_b      = sel ? ifb.alu_b      : ifa.alu_b;
   assign m_busy       = sel ? ifb.busy       : ifa.busy;
   assign m_op_count   = sel ? {13'b0, ifb.op_count} : ifa.op_count;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut=%0d: actual=%0h required=%0h t=%0t", name, sel, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int lat();
      return sel ? 3 : 1;
   endfunction

   function automatic logic [15:0] cnt_exp();
      return sel ? 16'(cnt_model[1] & 7) : 16'(cnt_model[0] & 16'hFFFF);
   endfunction

   // One isolated op with exact cycle timing.
   task automatic single_op(input vec_t v);
      logic [31:0] exp;
      d_cmd_valid = 1'b1; d_op = v.op; d_a = v.a; d_b = v.b; d_rsp_ready = 1'b1;
      chk("single_cmd_ready", m_cmd_ready, 1);
      step();
      d_cmd_valid = 1'b0;
      chk("single_no_bypass", m_alu_en, 0);
      chk("single_busy", m_busy, 1);
      step();
      exp = v.res + (sel ? (tick + 32'(lat() - 1)) : 32'd0);
      chk("single_alu_a", m_alu_a, v.a);
      chk("single_alu_b", m_alu_b, v.b);
      chk("single_alu_op", m_alu_opcode, v.op);
      for (int i = 0; i < lat(); i++) begin
         chk("single_alu_en_high", m_alu_en, 1);
         chk("single_rsp_early", m_rsp_valid, 0);
         step();
      end
      chk("single_alu_en_low", m_alu_en, 0);
      chk("single_rsp_valid", m_rsp_valid, 1);
      chk("single_rsp_result", m_rsp_result, exp);
      chk("single_rsp_opcode", m_rsp_opcode, v.op);
      step();
      cnt_model[sel]++;
      chk("single_rsp_clear", m_rsp_valid, 0);
      chk("single_op_count", m_op_count, cnt_exp());
      chk("single_alu_hold", m_alu_a, v.a);
      chk("single_idle", m_busy, 0);
   endtask

   // Random traffic against a queue-based reference of commands and results.
   task automatic rand_run(input int ncyc);
      logic   prev_en = m_alu_en;
      int     en_len  = 0;
      cmd_t   c;
      logic [34:0] e;
      pend.delete();
      iss.delete();
      for (int cyc = 0; cyc < ncyc + 300; cyc++) begin
         if (cyc < ncyc) begin
            d_cmd_valid = ($urandom_range(0, 99) < 60);
            d_op        = 3'($urandom);
            d_a         = $urandom;
            d_b         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            d_rsp_ready = ($urandom_range(0, 99) < 50);
         end else begin
            d_cmd_valid = 1'b0;
            d_rsp_ready = 1'b1;
            if (pend.size() + iss.size() == 0) break;
         end
         if (d_cmd_valid && m_cmd_ready) pend.push_back('{d_op, d_a, d_b});
         if (m_rsp_valid && d_rsp_ready) begin
            chk("rand_rsp_expected", (iss.size() != 0), 1);
            if (iss.size() != 0) begin
               e = iss.pop_front();
               chk("rand_rsp_result", m_rsp_result, e[31:0]);
               chk("rand_rsp_opcode", m_rsp_opcode, e[34:32]);
               cnt_model[sel]++;
            end
         end
         step();
         if (m_alu_en && !prev_en) begin
            chk("rand_one_in_flight", iss.size(), 0);
            chk("rand_issue_has_cmd", (pend.size() != 0), 1);
            if (pend.size() != 0) begin
               c = pend.pop_front();
               chk("rand_alu_op", m_alu_opcode, c.op);
               chk("rand_alu_a", m_alu_a, c.a);
               chk("rand_alu_b", m_alu_b, c.b);
               iss.push_back({c.op, alu_fn(c.op, c.a, c.b) +
                              (sel ? (tick + 32'(lat() - 1)) : 32'd0)});
            end
            en_len = 1;
         end else if (m_alu_en) begin
            en_len++;
         end
         if (!m_alu_en && prev_en) chk("rand_alu_en_len", en_len, lat());
         prev_en = m_alu_en;
         chk("rand_busy", m_busy, (pend.size() + iss.size() != 0));
         chk("rand_op_count", m_op_count, cnt_exp());
      end
      chk("rand_drain", pend.size() + iss.size(), 0);
   endtask

   initial begin
      int got;
      vecs[0] = '{3'd0, 32'd4,         32'd2,         32'd6};
      vecs[1] = '{3'd1, 32'd3,         32'd10,        32'hFFFF_FFF9};
      vecs[2] = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      vecs[3] = '{3'd3, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF};
      vecs[4] = '{3'd4, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA};
      vecs[5] = '{3'd5, 32'd1,         32'd4,         32'd16};
      vecs[6] = '{3'd6, 32'h8000_0000, 32'd31,        32'd1};
      vecs[7] = '{3'd7, 32'hFFFF_FFFF, 32'd1,         32'd1};
      cnt_model[0] = 0;
      cnt_model[1] = 0;

      // Reset state of both instances.
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk("reset_alu_en", m_alu_en, 0);
         chk("reset_rsp_valid", m_rsp_valid, 0);
         chk("reset_cmd_ready", m_cmd_ready, 1);
         chk("reset_busy", m_busy, 0);
         chk("reset_op_count", m_op_count, 0);
         chk("reset_rsp_result", m_rsp_result, 0);
         chk("reset_alu_a", m_alu_a, 0);
      end
      sel = 1'b0;
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) single_op(vecs[i]);

      // Backpressure: response held stable for 5 cycles.
      d_cmd_valid = 1'b1; d_op = 3'd0; d_a = 32'd100; d_b = 32'd23; d_rsp_ready = 1'b0;
      step();
      d_cmd_valid = 1'b0;
      for (int n = 0; n < 20 && !m_rsp_valid; n++) step();
      chk("bp_rsp_seen", m_rsp_valid, 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", m_rsp_valid, 1);
         chk("bp_rsp_result", m_rsp_result, 32'd123);
         chk("bp_alu_en", m_alu_en, 0);
         step();
      end
      d_rsp_ready = 1'b1;
      step();
      cnt_model[0]++;
      chk("bp_rsp_clear", m_rsp_valid, 0);
      chk("bp_op_count", m_op_count, cnt_exp());

      // Fill: 1 in flight + 4 queued, the sixth is refused.
      d_rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         d_cmd_valid = 1'b1; d_op = 3'd0; d_a = 32'(i * 10); d_b = 32'd1;
         chk("fill_accept", m_cmd_ready, (i < 5));
         step();
      end
      d_cmd_valid = 1'b0;
      repeat (3) begin
         chk("fill_full", m_cmd_ready, 0);
         chk("fill_busy", m_busy, 1);
         step();
      end
      d_rsp_ready = 1'b1;
      got = 0;
      for (int n = 0; n < 80 && got < 5; n++) begin
         if (m_rsp_valid) begin
            chk("fill_order", m_rsp_result, 32'(got * 10 + 1));
            got++;
            cnt_model[0]++;
         end
         step();
      end
      chk("fill_count", got, 5);
      step();
      chk("fill_idle", m_busy, 0);
      chk("fill_op_count", m_op_count, cnt_exp());

      // Asynchronous reset while alu_en is high.
      d_rsp_ready = 1'b0;
      d_cmd_valid = 1'b1; d_op = 3'd0; d_a = 32'd1; d_b = 32'd1;
      step();
      d_a = 32'd2;
      step();
      chk("rst_pre_alu_en", m_alu_en, 1);
      #2 rst_n = 1'b0;
      #1;
      cnt_model[0] = 0;
      cnt_model[1] = 0;
      chk("rst_alu_en", m_alu_en, 0);
      chk("rst_rsp_valid", m_rsp_valid, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_op_count", m_op_count, 0);
      chk("rst_cmd_ready", m_cmd_ready, 1);
      step();
      step();
      chk("rst_no_push", m_busy, 0);
      d_cmd_valid = 1'b0;
      #2 rst_n = 1'b1;
      step();
      step();
      chk("rst_queue_lost", m_busy, 0);
      chk("rst_no_issue", m_alu_en, 0);
      chk("rst_alu_a", m_alu_a, 0);
      chk("rst_no_rsp", m_rsp_valid, 0);

      // DUT B: ALU_LAT=3 capture timing; 8 ops wrap the 3-bit counter 7 -> 0.
      sel = 1'b1;
      #1;
      foreach (vecs[i]) begin
         single_op(vecs[i]);
         if (i == 6) chk("wrap_seven", m_op_count, 16'd7);
         if (i == 7) chk("wrap_zero", m_op_count, 16'd0);
      end

      sel = 1'b0;
      #1;
      rand_run(500);
      sel = 1'b1;
      #1;
      rand_run(500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
